stage_mem: RTL and testbench

- Memory stage of the 5-stage pipeline. Sits directly downstream of the execute stage and directly upstream of writeback.
- Contains the EX/MEM pipeline register and drives a req/ack data-memory port for LDR/STR.
- Stalls the upstream pipeline while an access is outstanding, and times out hung accesses with a sticky fault flag.
- Produces the registered MEM/WB result and a forwarding tap.

---
 rtl/stage_mem.sv | 172 +++++++++++++++++
 tb/tb_stage_mem.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// stage_mem: memory stage of the 5-stage pipeline.
//
// Holds the EX/MEM pipeline register and drives a req/ack data-memory port
// for LDR/STR. Stalls upstream while an access is outstanding and gives up
// after TIMEOUT_CYCLES cycles, raising a sticky fault. Produces the MEM/WB
// register and a forwarding tap from EX/MEM.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   ex_valid ... is_load_in  EX-stage outputs captured into EX/MEM
//   stall                 hold IF/ID/EX this cycle (combinational)
//   dmem_req/we/addr/wdata  data-memory request side
//   dmem_rdata/ack        data-memory response side
//   fwd_wen/rd_addr/data  forwarding tap from EX/MEM (non-load writes only)
//   wb_valid/reg_wen/rd_addr/data  registered MEM/WB outputs
//   mem_fault             sticky access-timeout flag
module stage_mem #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 4,
  parameter int unsigned DMEM_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_valid,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  input  logic [DATA_WIDTH-1:0]      store_data,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_in,
  input  logic                       reg_wen_in,
  input  logic                       mem_wen_in,
  input  logic                       is_mem_inst_in,
  input  logic                       is_load_in,
  output logic                       stall,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       fwd_wen,
  output logic [REG_ADDR_WIDTH-1:0]  fwd_rd_addr,
  output logic [DATA_WIDTH-1:0]      fwd_data,
  output logic                       wb_valid,
  output logic                       wb_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0]  wb_rd_addr,
  output logic [DATA_WIDTH-1:0]      wb_data,
  output logic                       mem_fault
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // EX/MEM register
  logic                      m_valid_q;
  logic [DATA_WIDTH-1:0]     m_alu_result_q;
  logic [DATA_WIDTH-1:0]     m_store_data_q;
  logic [REG_ADDR_WIDTH-1:0] m_rd_addr_q;
  logic                      m_reg_wen_q;
  logic                      m_mem_wen_q;
  logic                      m_is_mem_q;
  logic                      m_is_load_q;

  state_e                    state_q;
  logic [CntW-1:0]           cnt_q;
  logic                      mem_fault_q;

  logic                      wb_valid_q;
  logic                      wb_reg_wen_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;

  logic mem_op;
  logic timeout;
  logic done;

  always_comb begin
    mem_op  = m_valid_q & m_is_mem_q;
    // Ack in the last allowed cycle wins over the timeout.
    timeout = mem_op & (state_q == StWait) & ~dmem_ack & (cnt_q == CntLast);
    done    = m_valid_q & (~m_is_mem_q | dmem_ack | timeout);
    stall   = mem_op & ~done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q      <= 1'b0;
      m_alu_result_q <= '0;
      m_store_data_q <= '0;
      m_rd_addr_q    <= '0;
      m_reg_wen_q    <= 1'b0;
      m_mem_wen_q    <= 1'b0;
      m_is_mem_q     <= 1'b0;
      m_is_load_q    <= 1'b0;
    end else if (!stall) begin
      m_valid_q      <= ex_valid;
      m_alu_result_q <= alu_result;
      m_store_data_q <= store_data;
      m_rd_addr_q    <= rd_addr_in;
      m_reg_wen_q    <= reg_wen_in;
      m_mem_wen_q    <= mem_wen_in;
      m_is_mem_q     <= is_mem_inst_in;
      m_is_load_q    <= is_load_in;
    end
  end

  // Access FSM: cnt_q counts cycles spent on the current access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_op && !dmem_ack) begin
            state_q <= StWait;
            cnt_q   <= CntW'(1);
          end
        end
        StWait: begin
          if (dmem_ack || !mem_op) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register, updated every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_reg_wen_q <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_data_q    <= '0;
    end else begin
      wb_valid_q   <= done;
      wb_reg_wen_q <= done & m_reg_wen_q & ~timeout;
      wb_rd_addr_q <= m_rd_addr_q;
      wb_data_q    <= m_is_load_q ? dmem_rdata : m_alu_result_q;
    end
  end

  always_comb begin
    dmem_req    = mem_op;
    dmem_we     = mem_op & m_mem_wen_q;
    dmem_addr   = m_alu_result_q[DMEM_ADDR_WIDTH-1:0];
    dmem_wdata  = m_store_data_q;
    fwd_wen     = m_valid_q & m_reg_wen_q & ~m_is_load_q;
    fwd_rd_addr = m_rd_addr_q;
    fwd_data    = m_alu_result_q;
    wb_valid    = wb_valid_q;
    wb_reg_wen  = wb_reg_wen_q;
    wb_rd_addr  = wb_rd_addr_q;
    wb_data     = wb_data_q;
    mem_fault   = mem_fault_q;
  end

endmodule

// File: tb/tb_stage_mem.sv
// Testbench for stage_mem: directed scenarios plus a randomized instruction
// stream checked against a transaction-level model of the memory stage.
module tb_stage_mem;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ex_valid, reg_wen_in, mem_wen_in, is_mem_inst_in, is_load_in;
  logic [DW-1:0] alu_result, store_data;
  logic [RW-1:0] rd_addr_in;
  logic          stall, dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          fwd_wen, wb_valid, wb_reg_wen, mem_fault;
  logic [RW-1:0] fwd_rd_addr, wb_rd_addr;
  logic [DW-1:0] fwd_data, wb_data;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [RW-1:0] rd;
    logic          regw;
    logic          memw;
    logic          ismem;
    logic          isload;
    int unsigned   d;   // cycles without ack before ack arrives
  } instr_t;

  always #5 clk = ~clk;

  stage_mem #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (RW),
    .DMEM_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .rd_addr_in    (rd_addr_in),
    .reg_wen_in    (reg_wen_in),
    .mem_wen_in    (mem_wen_in),
    .is_mem_inst_in(is_mem_inst_in),
    .is_load_in    (is_load_in),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .fwd_wen       (fwd_wen),
    .fwd_rd_addr   (fwd_rd_addr),
    .fwd_data      (fwd_data),
    .wb_valid      (wb_valid),
    .wb_reg_wen    (wb_reg_wen),
    .wb_rd_addr    (wb_rd_addr),
    .wb_data       (wb_data),
    .mem_fault     (mem_fault)
  );

  task automatic drive_ex(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                          input logic [RW-1:0] rd, input logic regw, input logic memw,
                          input logic ismem, input logic isload);
    ex_valid = v; alu_result = alu; store_data = sd; rd_addr_in = rd;
    reg_wen_in = regw; mem_wen_in = memw; is_mem_inst_in = ismem; is_load_in = isload;
  endtask

  task automatic drive_idle();
    drive_ex(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic instr_t gen_instr();
    instr_t i;
    int unsigned kind = $urandom_range(0, 2);
    int unsigned r = $urandom_range(0, 9);
    i.v = ($urandom_range(0, 5) != 0);
    i.alu = $urandom;
    i.sd = $urandom;
    i.rd = RW'($urandom_range(0, 15));
    i.regw = 1'b0; i.memw = 1'b0; i.ismem = 1'b0; i.isload = 1'b0;
    if (kind == 0) begin
      i.regw = 1'($urandom_range(0, 1));
    end else begin
      i.alu[7:0] = 8'($urandom_range(0, 15));
      i.ismem = 1'b1;
      i.isload = (kind == 1);
      i.regw = (kind == 1);
      i.memw = (kind == 2);
    end
    i.d = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 5) : $urandom_range(TO - 1, TO + 3);
    return i;
  endfunction

  task automatic test_reset();
    drive_idle(); dmem_ack = 1'b0; dmem_rdata = '0;
    #2 rst_n = 1'b0;
    drive_ex(1'b1, 32'd5, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, fwd_wen, fwd_rd_addr, fwd_data,
         wb_valid, wb_reg_wen, wb_rd_addr, wb_data, mem_fault} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs, want all zero");
    end
    @(negedge clk); @(negedge clk); #1;
    total++;
    if ({stall, dmem_req, fwd_wen, wb_valid, wb_reg_wen, wb_data, mem_fault} !== '0) begin
      bad++; $display("FAIL reset_hold: got nonzero outputs while held in reset, want zero");
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_ex(1'b1, 32'h0000_0005, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle(); #1;
    total++;
    if ({fwd_wen, fwd_rd_addr, fwd_data, stall, dmem_req} !== {1'b1, 4'd3, 32'd5, 1'b0, 1'b0}) begin
      bad++; $display("FAIL alu_fwd: got wen=%b rd=%0d data=%0h stall=%b req=%b want 1 3 5 0 0",
                      fwd_wen, fwd_rd_addr, fwd_data, stall, dmem_req);
    end
    @(negedge clk); #1;
    total++;
    if ({wb_valid, wb_reg_wen, wb_rd_addr, wb_data, stall} !== {1'b1, 1'b1, 4'd3, 32'd5, 1'b0}) begin
      bad++; $display("FAIL alu_wb: got v=%b wen=%b rd=%0d data=%0h stall=%b want 1 1 3 5 0",
                      wb_valid, wb_reg_wen, wb_rd_addr, wb_data, stall);
    end
  endtask

  task automatic test_load_wait();
    @(negedge clk);
    drive_ex(1'b1, 32'h10, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({stall, dmem_req, dmem_we, dmem_addr, fwd_wen} !== {1'b1, 1'b1, 1'b0, 8'h10, 1'b0}) begin
        bad++; $display("FAIL load_wait_%0d: got stall=%b req=%b we=%b addr=%0h fwd=%b want 1 1 0 10 0",
                        i, stall, dmem_req, dmem_we, dmem_addr, fwd_wen);
      end
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; drive_idle(); #1;
    total++;
    if ({stall, dmem_req, dmem_addr} !== {1'b0, 1'b1, 8'h10}) begin
      bad++; $display("FAIL load_ack: got stall=%b req=%b addr=%0h want 0 1 10",
                      stall, dmem_req, dmem_addr);
    end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = '0; #1;
    total++;
    if ({wb_valid, wb_reg_wen, wb_rd_addr, wb_data} !== {1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL load_wb: got v=%b wen=%b rd=%0d data=%0h want 1 1 2 deadbeef",
                      wb_valid, wb_reg_wen, wb_rd_addr, wb_data);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_ex(1'b1, 32'h20, 32'h1234, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    dmem_ack = 1'b1; drive_idle(); #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall} !== {1'b1, 1'b1, 8'h20, 32'h1234, 1'b0}) begin
      bad++; $display("FAIL store_req: got req=%b we=%b addr=%0h wdata=%0h stall=%b want 1 1 20 1234 0",
                      dmem_req, dmem_we, dmem_addr, dmem_wdata, stall);
    end
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    total++;
    if ({wb_valid, wb_reg_wen, dmem_req, dmem_we} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL store_wb: got v=%b wen=%b req=%b we=%b want 1 0 0 0",
                      wb_valid, wb_reg_wen, dmem_req, dmem_we);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    drive_ex(1'b1, 32'h133, 32'h0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ack = 1'b0; dmem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (!stall) break;
      n++;
    end
    total++;
    if (n != TO - 1) begin
      bad++; $display("FAIL timeout_stall_cycles: got %0d want %0d", n, TO - 1);
    end
    total++;
    if ({dmem_req, dmem_addr, mem_fault} !== {1'b1, 8'h33, 1'b0}) begin
      bad++; $display("FAIL timeout_last_cycle: got req=%b addr=%0h fault=%b want 1 33 0",
                      dmem_req, dmem_addr, mem_fault);
    end
    drive_ex(1'b1, 32'd7, 32'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle(); #1;
    total++;
    if ({mem_fault, wb_valid, wb_reg_wen, fwd_wen, fwd_data, stall} !==
        {1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0}) begin
      bad++; $display("FAIL timeout_wb: got fault=%b v=%b wen=%b fwd=%b fdata=%0h stall=%b want 1 1 0 1 7 0",
                      mem_fault, wb_valid, wb_reg_wen, fwd_wen, fwd_data, stall);
    end
    @(negedge clk); #1;
    total++;
    if ({mem_fault, wb_valid, wb_reg_wen, wb_rd_addr, wb_data} !== {1'b1, 1'b1, 1'b1, 4'd1, 32'd7}) begin
      bad++; $display("FAIL timeout_next: got fault=%b v=%b wen=%b rd=%0d data=%0h want 1 1 1 1 7",
                      mem_fault, wb_valid, wb_reg_wen, wb_rd_addr, wb_data);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_ex(1'b1, 32'h40, 32'hAAAA_5555, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    dmem_ack = 1'b0;
    @(negedge clk);
    drive_ex(1'b1, 32'h41, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0; #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall} !== {1'b1, 1'b1, 8'h40, 32'hAAAA_5555, 1'b0}) begin
      bad++; $display("FAIL b2b_store: got req=%b we=%b addr=%0h wdata=%0h stall=%b want 1 1 40 aaaa5555 0",
                      dmem_req, dmem_we, dmem_addr, dmem_wdata, stall);
    end
    @(negedge clk);
    drive_idle(); dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D; #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, stall, wb_valid, wb_reg_wen} !==
        {1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL b2b_load: got req=%b we=%b addr=%0h stall=%b v=%b wen=%b want 1 0 41 0 1 0",
                      dmem_req, dmem_we, dmem_addr, stall, wb_valid, wb_reg_wen);
    end
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    total++;
    if ({dmem_req, wb_valid, wb_reg_wen, wb_rd_addr, wb_data} !==
        {1'b0, 1'b1, 1'b1, 4'd6, 32'hCAFE_F00D}) begin
      bad++; $display("FAIL b2b_wb: got req=%b v=%b wen=%b rd=%0d data=%0h want 0 1 1 6 cafef00d",
                      dmem_req, wb_valid, wb_reg_wen, wb_rd_addr, wb_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    @(negedge clk);
    drive_ex(1'b1, 32'h50, 32'h0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    total++;
    if ({stall, dmem_req} !== 2'b11) begin
      bad++; $display("FAIL rstwait_pre: got stall=%b req=%b want 1 1", stall, dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({stall, dmem_req, wb_valid, mem_fault} !== 4'b0000) begin
      bad++; $display("FAIL rstwait_async: got stall=%b req=%b v=%b fault=%b want 0 0 0 0",
                      stall, dmem_req, wb_valid, mem_fault);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({stall, dmem_req, wb_valid, mem_fault} !== 4'b0000) begin
      bad++; $display("FAIL rstwait_post: got stall=%b req=%b v=%b fault=%b want 0 0 0 0",
                      stall, dmem_req, wb_valid, mem_fault);
    end
    // Ack on the last allowed cycle: only completes without fault if the
    // wait counter restarted from zero after reset.
    drive_ex(1'b1, 32'h77, 32'h0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      dmem_ack = (k == int'(TO) - 1);
      dmem_rdata = 32'h600D_F00D;
      if (k == int'(TO) - 1) drive_idle();
      #1;
      if (stall) n++;
    end
    total++;
    if (n != TO - 1) begin
      bad++; $display("FAIL rstwait_late_ack_stall: got %0d want %0d", n, TO - 1);
    end
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    total++;
    if ({wb_valid, wb_reg_wen, wb_rd_addr, wb_data, mem_fault} !==
        {1'b1, 1'b1, 4'd9, 32'h600D_F00D, 1'b0}) begin
      bad++; $display("FAIL rstwait_late_ack_wb: got v=%b wen=%b rd=%0d data=%0h fault=%b want 1 1 9 600df00d 0",
                      wb_valid, wb_reg_wen, wb_rd_addr, wb_data, mem_fault);
    end
  endtask

  task automatic test_random();
    instr_t cur, nxt;
    bit have_cur = 1'b0;
    int unsigned k = 0;
    bit ack, done, tmo;
    bit ev = 1'b0, eregw = 1'b0, efault = 1'b0;
    logic [RW-1:0] erd = '0;
    logic [DW-1:0] edata = '0, rd_v;
    logic [DW-1:0] mem [256];
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    cur = '0;
    nxt = gen_instr();
    drive_idle(); dmem_ack = 1'b0;
    @(negedge clk);
    repeat (800) begin
      @(negedge clk);
      total++;
      if (wb_valid !== ev) begin
        bad++; $display("FAIL rnd_wb_valid: got %b want %b", wb_valid, ev);
      end
      total++;
      if (ev && {wb_reg_wen, wb_rd_addr, wb_data} !== {eregw, erd, edata}) begin
        bad++; $display("FAIL rnd_wb: got wen=%b rd=%0d data=%0h want %b %0d %0h",
                        wb_reg_wen, wb_rd_addr, wb_data, eregw, erd, edata);
      end else if (!ev && wb_reg_wen !== 1'b0) begin
        bad++; $display("FAIL rnd_wb_wen_idle: got %b want 0", wb_reg_wen);
      end
      total++;
      if (mem_fault !== efault) begin
        bad++; $display("FAIL rnd_fault: got %b want %b", mem_fault, efault);
      end
      drive_ex(nxt.v, nxt.alu, nxt.sd, nxt.rd, nxt.regw, nxt.memw, nxt.ismem, nxt.isload);
      ack = have_cur && cur.ismem && (k == cur.d);
      rd_v = (ack && cur.isload) ? mem[cur.alu[7:0]] : $urandom;
      dmem_ack = ack; dmem_rdata = rd_v;
      #1;
      done = have_cur && (!cur.ismem || ack || k == TO - 1);
      tmo = have_cur && cur.ismem && !ack && (k == TO - 1);
      total++;
      if ({stall, dmem_req} !== {have_cur && cur.ismem && !done, have_cur && cur.ismem}) begin
        bad++; $display("FAIL rnd_stall_req: got stall=%b req=%b want %b %b (k=%0d)",
                        stall, dmem_req, have_cur && cur.ismem && !done, have_cur && cur.ismem, k);
      end
      if (have_cur && cur.ismem) begin
        total++;
        if ({dmem_we, dmem_addr} !== {cur.memw, cur.alu[7:0]} ||
            (cur.memw && dmem_wdata !== cur.sd)) begin
          bad++; $display("FAIL rnd_dmem: got we=%b addr=%0h wdata=%0h want %b %0h %0h",
                          dmem_we, dmem_addr, dmem_wdata, cur.memw, cur.alu[7:0], cur.sd);
        end
      end
      total++;
      if (fwd_wen !== (have_cur && cur.regw && !cur.isload) ||
          (fwd_wen && {fwd_rd_addr, fwd_data} !== {cur.rd, cur.alu})) begin
        bad++; $display("FAIL rnd_fwd: got wen=%b rd=%0d data=%0h want %b %0d %0h",
                        fwd_wen, fwd_rd_addr, fwd_data, have_cur && cur.regw && !cur.isload,
                        cur.rd, cur.alu);
      end
      ev = done;
      if (done) begin
        erd = cur.rd;
        edata = cur.isload ? rd_v : cur.alu;
        eregw = cur.regw && !tmo;
        if (ack && cur.memw) mem[cur.alu[7:0]] = cur.sd;
      end
      if (tmo) efault = 1'b1;
      if (!have_cur || done) begin
        have_cur = nxt.v; cur = nxt; k = 0; nxt = gen_instr();
      end else begin
        k++;
      end
    end
    drive_idle(); dmem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
